// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, completer FSM states and the
// byte-strobe merge helper used by APB register completers.
package apb_pkg;

  localparam int APB_ADDR_W = 16;
  localparam int APB_DATA_W = 32;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } apb_state_e;

  function automatic logic [APB_DATA_W-1:0] apb_strb_merge(
    input logic [APB_DATA_W-1:0]   old_v,
    input logic [APB_DATA_W-1:0]   new_v,
    input logic [APB_DATA_W/8-1:0] strb
  );
    logic [APB_DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < APB_DATA_W/8; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_wait_ctrl.sv
// Wait-state counter for an APB completer: loaded at setup,
// counts down during access, ready once it reaches zero.
module apb_wait_ctrl #(
  parameter int WAIT_STATES = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic ready_o
);

  logic [3:0] wcnt_q;
  logic [3:0] wcnt_d;

  always_comb begin
    wcnt_d = wcnt_q;
    if (load_i) begin
      wcnt_d = 4'(WAIT_STATES);
    end else if (dec_i && (wcnt_q != 4'd0)) begin
      wcnt_d = wcnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wcnt_q <= 4'd0;
    else       wcnt_q <= wcnt_d;
  end

  assign ready_o = (wcnt_q == 4'd0);

endmodule

// File: rtl/apb_reg_completer.sv
// APB4 register-bank completer with ID/XFER_CNT status words, wait states
// and PSLVERR. Define APB_PROT_CHECK_EN to reject unprivileged RW writes.
module apb_reg_completer
  import apb_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     PCLKEN,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [APB_ADDR_W-1:0]    PADDR,
  input  logic [3:0]               PSTRB,
  input  logic [2:0]               PPROT,
  input  logic [APB_DATA_W-1:0]    PWDATA,
  output logic [APB_DATA_W-1:0]    PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  output logic [NUM_REGS*32-1:0]   reg_out
);

  localparam int IDX_W = APB_ADDR_W - 2;
  localparam logic [IDX_W-1:0] RW_END  = IDX_W'(NUM_REGS);
  localparam logic [IDX_W-1:0] ID_IDX  = IDX_W'(NUM_REGS);
  localparam logic [IDX_W-1:0] CNT_IDX = IDX_W'(NUM_REGS + 1);

  apb_state_e state_q, state_d;
  logic                   err_q, err_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [NUM_REGS-1:0][31:0] regs_q;

  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_mux;
  logic             is_rw, is_ro, prot_err, dec_err;
  logic             setup, access, wready;
  logic             load, dec, commit;
  logic             unused_pins;

  assign idx         = PADDR[APB_ADDR_W-1:2];
  assign unused_pins = ^{PPROT, PADDR[1:0]};

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (idx == IDX_W'(k)) rd_mux = regs_q[k];
    end
    if (idx == ID_IDX)  rd_mux = ID_VALUE;
    if (idx == CNT_IDX) rd_mux = cnt_q;
  end

  assign is_rw = (idx < RW_END);
  assign is_ro = (idx == ID_IDX) || (idx == CNT_IDX);

`ifdef APB_PROT_CHECK_EN
  assign prot_err = PWRITE && is_rw && !PPROT[0];
`else
  assign prot_err = 1'b0;
`endif

  assign dec_err = !(is_rw || is_ro) || (PWRITE && is_ro) || prot_err;

  assign setup  = PCLKEN && PSEL && !PENABLE;
  assign access = (state_q == ST_ACCESS);

  apb_wait_ctrl #(
    .WAIT_STATES(WAIT_STATES)
  ) u_wait (
    .clk_i  (HCLK),
    .rst_i  (HRESET),
    .load_i (load),
    .dec_i  (dec),
    .ready_o(wready)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    dec     = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (setup) begin
          err_d   = dec_err;
          rdata_d = rd_mux;
          idx_d   = idx;
          load    = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (PCLKEN) begin
          dec = !wready;
          if (!PSEL) begin
            state_d = ST_IDLE;
          end else if (PENABLE && wready) begin
            commit  = PWRITE && !err_q;
            cnt_d   = cnt_q + 32'd1;
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      rdata_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write data and strobes are taken from the completing cycle.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      regs_q <= '0;
    end else if (commit) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (idx_q == IDX_W'(k))
          regs_q[k] <= apb_strb_merge(regs_q[k], PWDATA, PSTRB);
      end
    end
  end

  assign PREADY  = access && wready;
  assign PRDATA  = (PREADY && !PWRITE) ? rdata_q : '0;
  assign PSLVERR = PREADY && err_q;
  assign reg_out = regs_q;

endmodule
